// File: rtl/dme_pwr_seq_if.sv
// Signal bundle between the board straps/rails and the DME power sequencer.
// The slave side is the sequencer; the master side drives the raw straps.
interface dme_pwr_seq_if;
   logic       PWRGD_PS_PWROK_3V3;
   logic       DME_Absent;
   logic       DME_PWRGD_RAW;
   logic [3:0] DMEID_RAW;
   logic       DME_PWR_EN;
   logic       DME_PWRGD;
   logic       DME_Present;
   logic [3:0] DMEID;
   logic       DME_Fault;
   logic [2:0] DMEState;

   modport master (
      output PWRGD_PS_PWROK_3V3, DME_Absent, DME_PWRGD_RAW, DMEID_RAW,
      input  DME_PWR_EN, DME_PWRGD, DME_Present, DMEID, DME_Fault, DMEState
   );

   modport slave (
      input  PWRGD_PS_PWROK_3V3, DME_Absent, DME_PWRGD_RAW, DMEID_RAW,
      output DME_PWR_EN, DME_PWRGD, DME_Present, DMEID, DME_Fault, DMEState
   );
endinterface

// File: rtl/dme_pwr_seq.sv
// DME power sequencer: synchronises and debounces the presence strap, gates the
// DME rail, qualifies its power-good with a timeout and latches the ID straps.
module dme_pwr_seq #(
   parameter int DEBOUNCE_CYC  = 16,
   parameter int PWRGD_TIMEOUT = 1000,
   parameter int ID_SETTLE     = 4,
   parameter int CNT_W         = 16
) (
   input  logic         CLK,
   input  logic         RST,
   dme_pwr_seq_if.slave bus
);
   typedef enum logic [2:0] {
      OFF     = 3'd0,
      WAIT_PG = 3'd1,
      SETTLE  = 3'd2,
      RUN     = 3'd3,
      FAULT   = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(PWRGD_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(ID_SETTLE - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   logic [2:0]       sync_p0, sync_p1;
   logic             pwrok_s, absent_s, pg_s;
   logic [CNT_W-1:0] deb_cnt;
   logic             present_q;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [3:0]       id_q, id_d;
   logic             fault_q, fault_d;
   logic             pwr_en_q, pwrgd_q;

   // Stage p0/p1: two-flop synchronisers for the asynchronous straps
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= {bus.PWRGD_PS_PWROK_3V3, bus.DME_Absent, bus.DME_PWRGD_RAW};
         sync_p1 <= sync_p0;
      end
   end

   assign pwrok_s  = sync_p1[2];
   assign absent_s = sync_p1[1];
   assign pg_s     = sync_p1[0];

   // Presence flips only after DEBOUNCE_CYC consecutive disagreeing samples
   always_ff @(posedge CLK) begin
      if (RST) begin
         deb_cnt   <= '0;
         present_q <= 1'b0;
      end else if (~absent_s == present_q) begin
         deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
         present_q <= ~absent_s;
         deb_cnt   <= '0;
      end else begin
         deb_cnt <= sat_inc(deb_cnt);
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      id_d    = id_q;
      fault_d = fault_q;
      if (state_q != OFF && (!pwrok_s || !present_q)) begin
         state_d = OFF;
      end else begin
         case (state_q)
            OFF: begin
               timer_d = '0;
               if (pwrok_s && present_q) begin
                  state_d = WAIT_PG;
                  fault_d = 1'b0;
               end
            end
            WAIT_PG: begin
               timer_d = sat_inc(timer_q);
               if (pg_s) begin
                  state_d = SETTLE;
                  timer_d = '0;
               end else if (timer_q == TMO_LAST) begin
                  state_d = FAULT;
               end
            end
            SETTLE: begin
               if (!pg_s) begin
                  state_d = FAULT;
               end else begin
                  timer_d = sat_inc(timer_q);
                  if (timer_q == SET_LAST) begin
                     state_d = RUN;
                     id_d    = bus.DMEID_RAW;
                  end
               end
            end
            RUN: begin
               if (!pg_s) state_d = FAULT;
            end
            FAULT: ;
            default: state_d = OFF;
         endcase
      end
      // Entry actions: ID forgotten on power-off, fault is sticky until a retry
      if (state_d == OFF && state_q != OFF) id_d = '0;
      if (state_d == FAULT && state_q != FAULT) fault_d = 1'b1;
   end

   // Stage p2: registered FSM state and outputs decoded from the next state
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= OFF;
         timer_q  <= '0;
         id_q     <= '0;
         fault_q  <= 1'b0;
         pwr_en_q <= 1'b0;
         pwrgd_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         id_q     <= id_d;
         fault_q  <= fault_d;
         pwr_en_q <= (state_d == WAIT_PG) || (state_d == SETTLE) || (state_d == RUN);
         pwrgd_q  <= (state_d == RUN);
      end
   end

   assign bus.DME_PWR_EN  = pwr_en_q;
   assign bus.DME_PWRGD   = pwrgd_q;
   assign bus.DME_Present = present_q;
   assign bus.DMEID       = id_q;
   assign bus.DME_Fault   = fault_q;
   assign bus.DMEState    = state_q;
endmodule

// File: tb/tb_dme_pwr_seq.sv
// Bench for dme_pwr_seq: directed bring-up/fault scenarios plus random strap
// activity, all compared every cycle against a behavioural model.
module tb_dme_pwr_seq;
   localparam int DEB = 4;
   localparam int TMO = 20;
   localparam int SET = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dme_pwr_seq_if bus ();

   dme_pwr_seq #(
      .DEBOUNCE_CYC (DEB),
      .PWRGD_TIMEOUT(TMO),
      .ID_SETTLE    (SET),
      .CNT_W        (16)
   ) dut (
      .CLK(clk),
      .RST(rst),
      .bus(bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // Behavioural model: raw-sample history, run length of disagreement,
   // state code and the edge index at which the state was entered.
   int       cyc = 0;
   bit [2:0] hist[$];
   bit       m_present;
   int       m_run;
   int       m_st;
   int       m_entry;
   bit       m_fault;
   bit [3:0] m_id;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, obs, exp, cyc);
   endtask

   task automatic model_step();
      bit [2:0] s;
      bit       pres_old;
      int       nst;
      cyc++;
      if (rst) begin
         hist      = '{3'b000, 3'b000};
         m_present = 1'b0;
         m_run     = 0;
         m_st      = 0;
         m_entry   = cyc;
         m_fault   = 1'b0;
         m_id      = 4'h0;
         return;
      end
      s = hist.pop_front();
      hist.push_back({bus.PWRGD_PS_PWROK_3V3, bus.DME_Absent, bus.DME_PWRGD_RAW});
      pres_old = m_present;
      if (!s[1] != m_present) begin
         m_run++;
         if (m_run == DEB) begin
            m_present = !s[1];
            m_run     = 0;
         end
      end else begin
         m_run = 0;
      end
      nst = m_st;
      if (m_st != 0 && !(s[2] && pres_old)) nst = 0;
      else begin
         case (m_st)
            0: if (s[2] && pres_old) nst = 1;
            1: if (s[0]) nst = 2; else if (cyc - m_entry == TMO) nst = 4;
            2: if (!s[0]) nst = 4; else if (cyc - m_entry == SET) nst = 3;
            3: if (!s[0]) nst = 4;
            default: ;
         endcase
      end
      if (nst != m_st) begin
         if (nst == 0) m_id = 4'h0;
         if (nst == 1) m_fault = 1'b0;
         if (nst == 3) m_id = bus.DMEID_RAW;
         if (nst == 4) m_fault = 1'b1;
         m_st    = nst;
         m_entry = cyc;
      end
   endtask

   task automatic compare_all();
      chk("pwr_en",  32'(bus.DME_PWR_EN),  32'(m_st >= 1 && m_st <= 3));
      chk("pwrgd",   32'(bus.DME_PWRGD),   32'(m_st == 3));
      chk("present", 32'(bus.DME_Present), 32'(m_present));
      chk("dmeid",   32'(bus.DMEID),       32'(m_id));
      chk("fault",   32'(bus.DME_Fault),   32'(m_fault));
      chk("state",   32'(bus.DMEState),    m_st);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   // Starts from OFF with the strap settled absent, pwrok high, pg low.
   task automatic bring_up(input logic [3:0] id);
      bus.DMEID_RAW  = id;
      bus.DME_Absent = 1'b0;
      repeat (5) tick();
      chk("up_present_pre", 32'(bus.DME_Present), 0);
      tick();
      chk("up_present", 32'(bus.DME_Present), 1);
      chk("up_still_off", 32'(bus.DMEState), 0);
      tick();
      chk("up_wait_pg", 32'(bus.DMEState), 1);
      chk("up_pwr_en", 32'(bus.DME_PWR_EN), 1);
      chk("up_fault_clr", 32'(bus.DME_Fault), 0);
      repeat (5) tick();
      bus.DME_PWRGD_RAW = 1'b1;
      repeat (5) tick();
      chk("up_settle", 32'(bus.DMEState), 2);
      chk("up_pwrgd_pre", 32'(bus.DME_PWRGD), 0);
      tick();
      chk("up_run", 32'(bus.DMEState), 3);
      chk("up_pwrgd", 32'(bus.DME_PWRGD), 1);
      chk("up_dmeid", 32'(bus.DMEID), 32'(id));
   endtask

   initial begin
      bus.PWRGD_PS_PWROK_3V3 = 1'b1;
      bus.DME_Absent         = 1'b1;
      bus.DME_PWRGD_RAW      = 1'b0;
      bus.DMEID_RAW          = 4'hA;
      rst = 1'b1;
      repeat (3) tick();
      chk("rst_pwr_en", 32'(bus.DME_PWR_EN), 0);
      chk("rst_present", 32'(bus.DME_Present), 0);
      chk("rst_state", 32'(bus.DMEState), 0);
      rst = 1'b0;
      repeat (6) tick();

      // Normal bring-up
      bring_up(4'hA);

      // Power-good lost in RUN
      bus.DME_PWRGD_RAW = 1'b0;
      repeat (2) tick();
      chk("pgloss_hold", 32'(bus.DMEState), 3);
      tick();
      chk("pgloss_fault_st", 32'(bus.DMEState), 4);
      chk("pgloss_pwrgd", 32'(bus.DME_PWRGD), 0);
      chk("pgloss_id_kept", 32'(bus.DMEID), 32'hA);
      chk("pgloss_fault", 32'(bus.DME_Fault), 1);
      chk("pgloss_pwr_en", 32'(bus.DME_PWR_EN), 0);

      // PSU drop keeps the fault visible, retry clears it, then timeout
      bus.PWRGD_PS_PWROK_3V3 = 1'b0;
      repeat (3) tick();
      chk("drop_off", 32'(bus.DMEState), 0);
      chk("drop_fault_kept", 32'(bus.DME_Fault), 1);
      chk("drop_id_clr", 32'(bus.DMEID), 0);
      bus.PWRGD_PS_PWROK_3V3 = 1'b1;
      repeat (3) tick();
      chk("retry_wait_pg", 32'(bus.DMEState), 1);
      chk("retry_fault_clr", 32'(bus.DME_Fault), 0);
      repeat (TMO - 1) tick();
      chk("tmo_not_yet", 32'(bus.DMEState), 1);
      tick();
      chk("tmo_state", 32'(bus.DMEState), 4);
      chk("tmo_fault", 32'(bus.DME_Fault), 1);
      chk("tmo_pwr_en", 32'(bus.DME_PWR_EN), 0);

      // Presence glitch shorter than the debounce window
      bus.DME_Absent = 1'b1;
      repeat (10) tick();
      chk("rm_off", 32'(bus.DMEState), 0);
      chk("rm_fault_kept", 32'(bus.DME_Fault), 1);
      bus.DME_Absent = 1'b0;
      repeat (DEB - 1) tick();
      bus.DME_Absent = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("glitch_present", 32'(bus.DME_Present), 0);
         chk("glitch_pwr_en", 32'(bus.DME_PWR_EN), 0);
      end
      bring_up(4'h5);

      // Hot removal from RUN
      bus.DME_Absent = 1'b1;
      repeat (5) tick();
      chk("hot_present_pre", 32'(bus.DME_Present), 1);
      tick();
      chk("hot_present", 32'(bus.DME_Present), 0);
      tick();
      chk("hot_off", 32'(bus.DMEState), 0);
      chk("hot_id_clr", 32'(bus.DMEID), 0);
      chk("hot_pwr_en", 32'(bus.DME_PWR_EN), 0);
      chk("hot_fault", 32'(bus.DME_Fault), 0);

      // Reset during SETTLE, then the same bring-up again
      bus.DME_Absent = 1'b0;
      repeat (8) tick();
      chk("pre_rst_settle", 32'(bus.DMEState), 2);
      rst = 1'b1;
      bus.DME_Absent    = 1'b1;
      bus.DME_PWRGD_RAW = 1'b0;
      tick();
      rst = 1'b0;
      chk("midrst_state", 32'(bus.DMEState), 0);
      chk("midrst_pwr_en", 32'(bus.DME_PWR_EN), 0);
      chk("midrst_present", 32'(bus.DME_Present), 0);
      repeat (6) tick();
      bring_up(4'hC);

      // Random strap activity with occasional resets
      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 79) == 0) bus.PWRGD_PS_PWROK_3V3 = ~bus.PWRGD_PS_PWROK_3V3;
         if ($urandom_range(0, 11) == 0) bus.DME_Absent = ~bus.DME_Absent;
         if ($urandom_range(0, 17) == 0) bus.DME_PWRGD_RAW = ~bus.DME_PWRGD_RAW;
         if (m_st == 0 && $urandom_range(0, 3) == 0) bus.DMEID_RAW = 4'($urandom);
         tick();
      end
      rst = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
